// File: rtl/guess_round_sequencer.sv
// Game sequencer for the 4-digit guess-number game: collects the secret and the guesses from
// keypad strobes, scores each guess serially (A/B), counts attempts and declares win or lose.
module guess_round_sequencer #(
    parameter int unsigned MAX_TRIES = 10,
    parameter int unsigned ATTEMPT_W = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic                 enter,
    input  logic                 clear,
    output logic [2:0]           state_num,
    output logic [3:0]           disp3,
    output logic [3:0]           disp2,
    output logic [3:0]           disp1,
    output logic [3:0]           disp0,
    output logic [2:0]           entry_cnt,
    output logic [2:0]           a_count,
    output logic [2:0]           b_count,
    output logic [ATTEMPT_W-1:0] attempts,
    output logic                 result_valid,
    output logic                 win,
    output logic                 lose,
    output logic                 dup_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SECRET = 3'd1,
        S_GUESS  = 3'd2,
        S_SCORE  = 3'd3,
        S_RESULT = 3'd4,
        S_WIN    = 3'd5,
        S_LOSE   = 3'd6
    } state_t;

    state_t     state;
    logic [3:0] dbuf   [4];
    logic [3:0] secret [4];
    logic [3:0] guess  [4];
    logic [3:0] idx;
    logic       key_dup;
    logic       match;

    assign state_num = state;
    assign disp3     = dbuf[3];
    assign disp2     = dbuf[2];
    assign disp1     = dbuf[1];
    assign disp0     = dbuf[0];
    assign win       = (state == S_WIN);
    assign lose      = (state == S_LOSE);

    // Only slots below entry_cnt hold live digits; the rest are zero fill.
    always_comb begin
        key_dup = ((entry_cnt > 3'd0) && (dbuf[0] == key_code)) ||
                  ((entry_cnt > 3'd1) && (dbuf[1] == key_code)) ||
                  ((entry_cnt > 3'd2) && (dbuf[2] == key_code)) ||
                  ((entry_cnt > 3'd3) && (dbuf[3] == key_code));
        match   = (secret[idx[3:2]] == guess[idx[1:0]]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            dbuf         <= '{default: '0};
            secret       <= '{default: '0};
            guess        <= '{default: '0};
            idx          <= '0;
            entry_cnt    <= '0;
            a_count      <= '0;
            b_count      <= '0;
            attempts     <= '0;
            result_valid <= 1'b0;
            dup_err      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            dup_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_SECRET;
                end
                S_SECRET, S_GUESS: begin
                    if (clear) begin
                        dbuf      <= '{default: '0};
                        entry_cnt <= '0;
                    end else if (enter) begin
                        if (entry_cnt == 3'd4) begin
                            if (state == S_SECRET) begin
                                secret    <= dbuf;
                                dbuf      <= '{default: '0};
                                entry_cnt <= '0;
                                state     <= S_GUESS;
                            end else begin
                                guess   <= dbuf;
                                a_count <= '0;
                                b_count <= '0;
                                idx     <= '0;
                                state   <= S_SCORE;
                            end
                        end
                    end else if (key_valid && (key_code <= 4'd9) && (entry_cnt < 3'd4)) begin
                        if (key_dup) begin
                            dup_err <= 1'b1;
                        end else begin
                            dbuf[3]   <= dbuf[2];
                            dbuf[2]   <= dbuf[1];
                            dbuf[1]   <= dbuf[0];
                            dbuf[0]   <= key_code;
                            entry_cnt <= entry_cnt + 3'd1;
                        end
                    end
                end
                S_SCORE: begin
                    if (match) begin
                        if (idx[3:2] == idx[1:0]) a_count <= a_count + 3'd1;
                        else                      b_count <= b_count + 3'd1;
                    end
                    idx <= idx + 4'd1;
                    if (idx == 4'hF) begin
                        state        <= S_RESULT;
                        attempts     <= attempts + ATTEMPT_W'(1);
                        result_valid <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (a_count == 3'd4) begin
                        state <= S_WIN;
                    end else if (attempts == ATTEMPT_W'(MAX_TRIES)) begin
                        state <= S_LOSE;
                    end else begin
                        state     <= S_GUESS;
                        dbuf      <= '{default: '0};
                        entry_cnt <= '0;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (start) begin
                        state     <= S_SECRET;
                        attempts  <= '0;
                        a_count   <= '0;
                        b_count   <= '0;
                        dbuf      <= '{default: '0};
                        entry_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
